// File: rtl/counter_priority_servicer_pkg.sv
// Shared types and constants for the counter priority servicer.
// The optional overflow-chaining feature is selected by CTR_OVERFLOW_CHAIN_EN.
package counter_priority_servicer_pkg;

  // Two-state offer FSM.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  // Direction of a service request: increment (PINC) or decrement (MINC).
  localparam logic DIR_PINC = 1'b1;
  localparam logic DIR_MINC = 1'b0;

  // Erasable address of channel 0 unless overridden.
  localparam logic [5:0] ADDR_BASE_DEFAULT = 6'o32;

  // Counter address for a channel index.
  function automatic logic [5:0] chan_addr(input logic [5:0] base, input logic [5:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/counter_priority_servicer_prio_enc.sv
// Lowest-index priority encoder: found is high when any request bit is set,
// index is the position of the lowest set bit (0 when none).
module ctr_prio_enc #(
  parameter int NCH = 16,
  localparam int IW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  output logic           found,
  output logic [IW-1:0]  index
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/counter_priority_servicer.sv
// Counter priority servicer: latches per-channel plus/minus pulses and offers
// one pending count at a time to the sequencer, lowest channel first.
// Optional feature: CTR_OVERFLOW_CHAIN_EN chains an accepted increment that
// overflowed into a plus pulse on the next channel.
//
// Handshake: svc_valid is high for the whole offer and svc_addr/svc_dir are
// held constant while it is high; a transfer happens on every rising edge
// where svc_valid and svc_ready are both high. svc_valid never depends
// combinationally on svc_ready, and an offer is only abandoned by rst.
module counter_priority_servicer
  import counter_priority_servicer_pkg::*;
#(
  parameter int         NCH       = 16,
  parameter logic [5:0] ADDR_BASE = ADDR_BASE_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] cnt_p,
  input  logic [NCH-1:0] cnt_m,
  input  logic           inhibit,
  output logic           svc_valid,
  output logic [5:0]     svc_addr,
  output logic           svc_dir,
  input  logic           svc_ready,
  output logic [NCH-1:0] pending,
  input  logic           svc_ovf,
  output logic           dbg_state
);

  localparam int IW = $clog2(NCH);

  state_t         state, state_nxt;
  logic [NCH-1:0] p_lat, m_lat, p_nxt, m_nxt;
  logic [NCH-1:0] clr_p, clr_m, chain, both;
  logic [IW-1:0]  cap_idx, cap_idx_nxt;
  logic           cap_dir, cap_dir_nxt;
  logic           found;
  logic [IW-1:0]  win_idx;
  logic           accept;

  // A channel holding both latches nets to zero and is never eligible.
  ctr_prio_enc #(.NCH(NCH)) u_enc (
    .req   (p_lat ^ m_lat),
    .found (found),
    .index (win_idx)
  );

  assign accept = (state == ST_OFFER) && svc_ready;

  // Next-state and capture logic; the captured channel/direction only
  // change when a new offer starts, so the outputs stay stable in OFFER.
  always_comb begin
    state_nxt   = state;
    cap_idx_nxt = cap_idx;
    cap_dir_nxt = cap_dir;
    case (state)
      ST_IDLE: begin
        if (!inhibit && found) begin
          state_nxt   = ST_OFFER;
          cap_idx_nxt = win_idx;
          cap_dir_nxt = p_lat[win_idx] ? DIR_PINC : DIR_MINC;
        end
      end
      ST_OFFER: begin
        if (svc_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifndef CTR_OVERFLOW_CHAIN_EN
  logic unused_svc_ovf;
  assign unused_svc_ovf = svc_ovf;
`endif

  // Latch update: acceptance clears only the captured latch, double-set
  // channels cancel, and a fresh pulse always wins over any clear.
  always_comb begin
    clr_p = '0;
    clr_m = '0;
    chain = '0;
    both  = p_lat & m_lat;
    if (accept) begin
      if (cap_dir == DIR_PINC) clr_p[cap_idx] = 1'b1;
      else                     clr_m[cap_idx] = 1'b1;
    end
`ifdef CTR_OVERFLOW_CHAIN_EN
    if (accept && (cap_dir == DIR_PINC) && svc_ovf && (int'(cap_idx) < NCH - 1))
      chain[int'(cap_idx) + 1] = 1'b1;
`endif
    p_nxt = cnt_p | chain | (p_lat & ~clr_p & ~both);
    m_nxt = cnt_m | (m_lat & ~clr_m & ~both);
  end

  // State and latch registers; reset discards everything including pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      p_lat   <= '0;
      m_lat   <= '0;
      cap_idx <= '0;
      cap_dir <= DIR_MINC;
    end else begin
      state   <= state_nxt;
      p_lat   <= p_nxt;
      m_lat   <= m_nxt;
      cap_idx <= cap_idx_nxt;
      cap_dir <= cap_dir_nxt;
    end
  end

  assign svc_valid = (state == ST_OFFER);
  assign svc_addr  = chan_addr(ADDR_BASE, 6'(cap_idx));
  assign svc_dir   = cap_dir;
  assign pending   = p_lat | m_lat;
  assign dbg_state = state;

endmodule

// File: tb/tb_counter_priority_servicer.sv
// Testbench for counter_priority_servicer: directed pulses, a scoreboard of
// expected offers {dir, addr} and a monitor that pops on every acceptance.
module tb_counter_priority_servicer;

  localparam int NCH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] cnt_p, cnt_m;
  logic           inhibit, svc_ready, svc_ovf;
  logic           svc_valid, svc_dir, dbg_state;
  logic [5:0]     svc_addr;
  logic [NCH-1:0] pending;

  logic [6:0] exp_q[$];
  int         acc_cyc[$];
  int         n_pass = 0;
  int         n_checks = 0;
  int         valid_cnt = 0;
  int         cyc = 0;

  counter_priority_servicer #(.NCH(NCH), .ADDR_BASE(6'o32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_p     (cnt_p),
    .cnt_m     (cnt_m),
    .inhibit   (inhibit),
    .svc_valid (svc_valid),
    .svc_addr  (svc_addr),
    .svc_dir   (svc_dir),
    .svc_ready (svc_ready),
    .pending   (pending),
    .svc_ovf   (svc_ovf),
    .dbg_state (dbg_state)
  );

  // Clock and reset-free cycle source.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [NCH-1:0] p, input logic [NCH-1:0] m);
    cnt_p = p;
    cnt_m = m;
    tick();
    cnt_p = '0;
    cnt_m = '0;
  endtask

  // Bounded wait for the scoreboard to drain, then confirm it is empty.
  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: pops on every accepted offer and checks offer stability.
  task automatic monitor();
    logic       prev_valid;
    logic [6:0] prev_offer;
    logic [6:0] exp;
    prev_valid = 1'b0;
    prev_offer = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && svc_valid) begin
        valid_cnt++;
        if (prev_valid) check("offer_stable", {svc_dir, svc_addr}, prev_offer);
        if (svc_ready) begin
          acc_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            check("unexpected_offer", {svc_dir, svc_addr}, 7'h7f);
          end else begin
            exp = exp_q.pop_front();
            check("offer", {svc_dir, svc_addr}, exp);
          end
        end
      end
      prev_valid = !rst && svc_valid && !svc_ready;
      prev_offer = {svc_dir, svc_addr};
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst = 1'b1; cnt_p = '0; cnt_m = '0;
    inhibit = 1'b0; svc_ready = 1'b0; svc_ovf = 1'b0;
    idle(3);
    check("rst_valid", svc_valid, 0);
    check("rst_addr", svc_addr, 6'o32);
    check("rst_dir", svc_dir, 0);
    check("rst_pending", pending, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    idle(2);

    // Single increment on channel 3, ready held high.
    svc_ready = 1'b1; valid_cnt = 0;
    exp_q.push_back({1'b1, 6'o35});
    pulse(16'h0008, '0);
    check("t1_pending_set", pending, 16'h0008);
    check("t1_not_yet_valid", svc_valid, 0);
    tick();
    check("t1_valid", svc_valid, 1);
    idle(4);
    check("t1_pending_clr", pending, 0);
    check("t1_valid_cycles", valid_cnt, 1);
    drain("t1_drain");

    // Two channels in the same cycle: lowest first, two cycles apart.
    acc_cyc.delete();
    exp_q.push_back({1'b1, 6'o34});
    exp_q.push_back({1'b1, 6'o37});
    pulse(16'h0024, '0);
    idle(6);
    drain("t2_drain");
    check("t2_acc_count", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("t2_interval", acc_cyc[1] - acc_cyc[0], 2);

    // Plus then minus on channel 1 under inhibit cancels; no offer later.
    inhibit = 1'b1; valid_cnt = 0;
    pulse(16'h0002, '0);
    check("t3_pending_p", pending, 16'h0002);
    pulse('0, 16'h0002);
    tick();
    check("t3_pending_cancel", pending, 0);
    inhibit = 1'b0;
    idle(6);
    check("t3_no_offer", valid_cnt, 0);

    // Channel 0 held for 5 cycles; re-pulse in the accept cycle wins.
    svc_ready = 1'b0;
    exp_q.push_back({1'b1, 6'o32});
    exp_q.push_back({1'b1, 6'o32});
    pulse(16'h0001, '0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", svc_valid, 1);
      check("t4_hold_addr", svc_addr, 6'o32);
      inhibit = (i == 2);
      tick();
    end
    inhibit = 1'b0;
    svc_ready = 1'b1;
    pulse(16'h0001, '0);
    check("t4_relatch", pending, 16'h0001);
    idle(4);
    drain("t4_drain");
    check("t4_pending_end", pending, 0);

    // Reset in the middle of an offer, pulses during reset are dropped.
    svc_ready = 1'b0;
    pulse(16'h0010, 16'h0080);
    check("t5_pending", pending, 16'h0090);
    tick();
    check("t5_offer_addr", svc_addr, 6'o36);
    rst = 1'b1;
    cnt_p = 16'h0040;
    tick();
    cnt_p = '0;
    check("t5_rst_valid", svc_valid, 0);
    check("t5_rst_pending", pending, 0);
    rst = 1'b0; svc_ready = 1'b1; valid_cnt = 0;
    idle(8);
    check("t5_no_offer", valid_cnt, 0);

    // Decrements including the top channel, mixed with an increment.
    exp_q.push_back({1'b1, 6'o32});
    exp_q.push_back({1'b0, 6'o43});
    exp_q.push_back({1'b0, 6'o51});
    pulse(16'h0001, 16'h8200);
    idle(8);
    drain("t7_drain");
    check("t7_pending_end", pending, 0);

    // Overflow on an accepted increment of channel 2.
    valid_cnt = 0;
    exp_q.push_back({1'b1, 6'o34});
`ifdef CTR_OVERFLOW_CHAIN_EN
    exp_q.push_back({1'b1, 6'o35});
`endif
    pulse(16'h0004, '0);
    tick();
    svc_ovf = 1'b1;
    tick();
    svc_ovf = 1'b0;
    idle(6);
    drain("t6_drain");
`ifdef CTR_OVERFLOW_CHAIN_EN
    check("t6_offers", valid_cnt, 2);
`else
    check("t6_offers", valid_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_priority_servicer.md
COUNTER_PRIORITY_SERVICER -- requirements
Module: counter_priority_servicer

Interface
REQ-001 Parameter NCH, default 16: number of counter channels; legal range 2..32.
REQ-002 Parameter ADDR_BASE, default 6'o32: erasable address of channel 0.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cnt_p  input  NCH  one-cycle plus-pulse per channel (e.g. CDUXP, PIPXP).
REQ-006 cnt_m  input  NCH  one-cycle minus-pulse per channel.
REQ-007 inhibit  input  1  when high, no new offer starts; pulses still latch.
REQ-008 svc_valid  output  1  service request offered to the sequencer.
REQ-009 svc_addr  output  6  counter address, ADDR_BASE + channel index.
REQ-010 svc_dir  output  1  1 = increment (PINC), 0 = decrement (MINC).
REQ-011 svc_ready  input  1  sequencer accepts the offer in this cycle.
REQ-012 pending  output  NCH  per-channel OR of plus and minus latches.
REQ-013 svc_ovf  input  1  overflow of the accepted increment; only meaningful with REQ-030.

Function
REQ-014 Each channel SHALL hold one plus latch and one minus latch; a pulse sets its latch on the next edge.
REQ-015 A channel with both latches set SHALL have both cleared on the next edge and SHALL never be offered (net zero).
REQ-016 The FSM SHALL have exactly two states, IDLE and OFFER.
REQ-017 In IDLE with inhibit low and at least one channel holding exactly one latch, the FSM SHALL capture the lowest-index such channel and enter OFFER on the next edge.
REQ-018 svc_valid SHALL be high exactly in OFFER; svc_addr and svc_dir SHALL be stable for the whole OFFER state.
REQ-019 In OFFER with svc_ready high, the captured latch SHALL clear and the FSM SHALL return to IDLE on that edge; minimum service interval is two cycles.
REQ-020 In OFFER with svc_ready low, the FSM SHALL hold; inhibit SHALL NOT withdraw an offer already made.
REQ-021 A new pulse on the latch being cleared in the same cycle SHALL win: the latch stays set.
REQ-022 An opposite-direction pulse on the offered channel during OFFER SHALL latch normally; cancellation per REQ-015 SHALL not affect the captured direction. The acceptance still clears only the captured latch.
REQ-023 Lower-index arrivals during OFFER SHALL NOT pre-empt the current offer.
REQ-024 pending SHALL reflect the latch state registered on the current cycle (no combinational path from cnt_p/cnt_m).

Reset
REQ-025 With rst high, all latches SHALL clear, the FSM SHALL enter IDLE, and svc_valid SHALL be 0. svc_addr SHALL be ADDR_BASE, svc_dir SHALL be 0, and pending SHALL be all-zero on the next edge.
REQ-026 Pulses arriving while rst is high SHALL be discarded.
REQ-027 rst asserted during OFFER SHALL abandon the offer without requiring svc_ready.

Configuration
REQ-028 Macro CTR_OVERFLOW_CHAIN_EN SHALL select overflow chaining.
REQ-029 Without the macro, svc_ovf SHALL be ignored.
REQ-030 With the macro, svc_ovf high on an accepted increment of channel k<NCH-1 SHALL set the plus latch of channel k+1 on the same edge. On channel NCH-1 it SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the direction encoding (DIR_PINC=1, DIR_MINC=0) and the default ADDR_BASE constant.
REQ-032 The lowest-index priority encoder SHALL be a separate sub-module, ctr_prio_enc, combinational, NCH-parameterised, with outputs found and index.

Verification
REQ-033 Pulse cnt_p[3], svc_ready held high -> svc_valid one cycle, svc_addr=6'o35, svc_dir=1, pending[3] back to 0 afterwards.
REQ-034 Same-cycle cnt_p[5] and cnt_p[2], svc_ready high -> offers 6'o34 then 6'o37, each 2 cycles apart.
REQ-035 cnt_p[1] then cnt_m[1] before the grant, inhibit high -> pending[1]=0, no offer when inhibit drops.
REQ-036 Offer on channel 0 with svc_ready low for 5 cycles; cnt_p[0] pulses during the accept cycle -> addr stable for all 5 cycles, second offer on 6'o32 follows.
REQ-037 rst pulsed mid-OFFER with pending on channels 4 and 7 -> svc_valid=0 and pending=0 next cycle, with no later offers.
REQ-038 With CTR_OVERFLOW_CHAIN_EN: accept an increment of channel 2 with svc_ovf=1 -> next offer 6'o35 with svc_dir=1; without the macro, no further offer.
